// File: rtl/lc3b_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : lc3b_mem_arbiter_if
// Description : Bundles the fetch, data and physical-memory handshakes of the
//               LC-3b memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface lc3b_mem_arbiter_if;
    logic        i_read;
    logic [15:0] i_address;
    logic [15:0] i_rdata;
    logic        i_resp;

    logic        d_read;
    logic        d_write;
    logic [1:0]  d_byte_enable;
    logic [15:0] d_address;
    logic [15:0] d_wdata;
    logic [15:0] d_rdata;
    logic        d_resp;

    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_byte_enable;
    logic [15:0] mem_address;
    logic [15:0] mem_wdata;
    logic        mem_resp;
    logic [15:0] mem_rdata;

    // Arbiter view.
    modport slave (
        input  i_read, i_address, d_read, d_write, d_byte_enable, d_address, d_wdata,
               mem_resp, mem_rdata,
        output i_rdata, i_resp, d_rdata, d_resp,
               mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata
    );

    // Environment view: requesters plus physical memory.
    modport master (
        output i_read, i_address, d_read, d_write, d_byte_enable, d_address, d_wdata,
               mem_resp, mem_rdata,
        input  i_rdata, i_resp, d_rdata, d_resp,
               mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/lc3b_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : lc3b_mem_arbiter
// Description : Round-robin arbiter joining the LC-3b fetch and data ports onto
//               one physical memory port with latched request signals.
// Revision    : 1.0 - initial release
// ============================================================================
module lc3b_mem_arbiter #(
    parameter bit I_FIRST = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    lc3b_mem_arbiter_if.slave  bus
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_GRANT_I = 2'd1;
    localparam logic [1:0] S_GRANT_D = 2'd2;

    logic [1:0]  r_state;
    logic        r_ptr_i;
    logic        r_mem_read;
    logic        r_mem_write;
    logic [1:0]  r_mem_byte_enable;
    logic [15:0] r_mem_address;
    logic [15:0] r_mem_wdata;

    logic w_req_i;
    logic w_req_d;
    logic w_grant_i;
    logic w_grant_d;

    assign w_req_i   = bus.i_read;
    assign w_req_d   = bus.d_read | bus.d_write;
    // r_ptr_i set means the I-side wins a simultaneous conflict.
    assign w_grant_i = w_req_i & (~w_req_d | r_ptr_i);
    assign w_grant_d = w_req_d & (~w_req_i | ~r_ptr_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state           <= S_IDLE;
            r_ptr_i           <= I_FIRST;
            r_mem_read        <= 1'b0;
            r_mem_write       <= 1'b0;
            r_mem_byte_enable <= 2'b00;
            r_mem_address     <= 16'h0000;
            r_mem_wdata       <= 16'h0000;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_i) begin
                        r_state           <= S_GRANT_I;
                        r_ptr_i           <= 1'b0;
                        r_mem_read        <= 1'b1;
                        r_mem_write       <= 1'b0;
                        r_mem_byte_enable <= 2'b11;
                        r_mem_address     <= bus.i_address;
                        r_mem_wdata       <= 16'h0000;
                    end else if (w_grant_d) begin
                        // A write wins over a read raised in the same request.
                        r_state           <= S_GRANT_D;
                        r_ptr_i           <= 1'b1;
                        r_mem_read        <= ~bus.d_write;
                        r_mem_write       <= bus.d_write;
                        r_mem_byte_enable <= bus.d_byte_enable;
                        r_mem_address     <= bus.d_address;
                        r_mem_wdata       <= bus.d_wdata;
                    end
                end
                S_GRANT_I, S_GRANT_D: begin
                    if (bus.mem_resp) begin
                        r_state     <= S_IDLE;
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_mem_read  <= 1'b0;
                    r_mem_write <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_read        = r_mem_read;
    assign bus.mem_write       = r_mem_write;
    assign bus.mem_byte_enable = r_mem_byte_enable;
    assign bus.mem_address     = r_mem_address;
    assign bus.mem_wdata       = r_mem_wdata;

    assign bus.i_rdata = bus.mem_rdata;
    assign bus.d_rdata = bus.mem_rdata;
    assign bus.i_resp  = (r_state == S_GRANT_I) & bus.mem_resp;
    assign bus.d_resp  = (r_state == S_GRANT_D) & bus.mem_resp;

endmodule
`default_nettype wire
